background_fetch: RTL and testbench

BACKGROUND_FETCH -- requirements
Module: background_fetch

---
 rtl/bg_pkg.sv | 12 +
 rtl/bg_addr_calc.sv | 24 ++
 rtl/background_fetch.sv | 72 +++++++
 tb/tb_background_fetch.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/bg_pkg.sv
// bg_pkg: shared widths, defaults and pipeline state encoding for background_fetch.
package bg_pkg;
  localparam int ADDR_W = 15;
  localparam int IMG_W_LOG2_DEF = 7;
  localparam int COORD_W = 10;
  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    S2_ONLY = 2'b01,
    S1_ONLY = 2'b10,
    BOTH    = 2'b11
  } state_t;
endpackage

// File: rtl/bg_addr_calc.sv
// bg_addr_calc: maps a screen coordinate to the window-inside flag and image memory address.
module bg_addr_calc import bg_pkg::*; #(
  parameter int X0 = 64,
  parameter int Y0 = 0,
  parameter int SCALE_SHIFT = 2,
  parameter int IMG_W_LOG2 = IMG_W_LOG2_DEF
) (
  input  logic [COORD_W-1:0] draw_x_i,
  input  logic [COORD_W-1:0] draw_y_i,
  output logic               inside_o,
  output logic [ADDR_W-1:0]  addr_o
);
  localparam int CW = COORD_W + 1;
  logic [CW-1:0] dx, dy, dxs, dys;
  always_comb begin
    dx = {1'b0, draw_x_i} - CW'(X0);
    dy = {1'b0, draw_y_i} - CW'(Y0);
    dxs = dx >> SCALE_SHIFT;
    dys = dy >> SCALE_SHIFT;
    // wrapped differences below X0/Y0 land far above the window size
    inside_o = ((dx >> (IMG_W_LOG2 + SCALE_SHIFT)) == '0) && ((dy >> (IMG_W_LOG2 + SCALE_SHIFT)) == '0);
    addr_o = inside_o ? ADDR_W'({dys[IMG_W_LOG2-1:0], dxs[IMG_W_LOG2-1:0]}) : '0;
  end
endmodule

// File: rtl/background_fetch.sv
// background_fetch: two-stage pipelined background pixel lookup against a
// synchronous 1-bit image memory, with valid/ready on both sides.
module background_fetch import bg_pkg::*; #(
  parameter int X0 = 64,
  parameter int Y0 = 0,
  parameter int SCALE_SHIFT = 2,
  parameter int IMG_W_LOG2 = IMG_W_LOG2_DEF
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  output logic [ADDR_W-1:0]  read_address,
  input  logic               mem_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               pixel_on,
  output logic               in_window
);
  state_t state_q, state_d;
  logic s1_valid, s2_valid, s2_adv, accept, pix_now;
  logic calc_inside;
  logic [ADDR_W-1:0] calc_addr;
  logic s1_inside_q, s2_inside_q, s2_fresh_q, s2_pix_q;
  logic [ADDR_W-1:0] s1_addr_q;

  bg_addr_calc #(
    .X0(X0), .Y0(Y0), .SCALE_SHIFT(SCALE_SHIFT), .IMG_W_LOG2(IMG_W_LOG2)
  ) u_calc (
    .draw_x_i(DrawX),
    .draw_y_i(DrawY),
    .inside_o(calc_inside),
    .addr_o  (calc_addr)
  );

  always_comb begin
    s1_valid = state_q[1];
    s2_valid = state_q[0];
    s2_adv = !s2_valid || out_ready;
    req_ready = !Reset && (!s1_valid || s2_adv);
    accept = req_valid && req_ready;
    state_d = state_t'({accept || (s1_valid && !s2_adv), s2_adv ? s1_valid : s2_valid});
    // memory data is live only in the first S2 cycle; afterwards the captured copy holds
    pix_now = s2_fresh_q ? mem_data : s2_pix_q;
    out_valid = s2_valid;
    in_window = s2_valid && s2_inside_q;
    pixel_on = s2_valid && s2_inside_q && pix_now;
    read_address = s1_addr_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= EMPTY;
      s1_inside_q <= 1'b0;
      s1_addr_q <= '0;
      s2_inside_q <= 1'b0;
      s2_fresh_q <= 1'b0;
      s2_pix_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        s1_inside_q <= calc_inside;
        s1_addr_q <= calc_addr;
      end
      if (s2_adv) s2_inside_q <= s1_inside_q;
      s2_fresh_q <= s2_adv && s1_valid;
      s2_pix_q <= pix_now;
    end
  end
endmodule

// File: tb/tb_background_fetch.sv
// tb_background_fetch: directed vectors plus a queue-based reference model of
// the background lookup, backed by a synchronous 1-bit memory model.
module tb_background_fetch;
  localparam int X0 = 64;
  localparam int Y0 = 0;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic req_valid = 1'b0;
  logic out_ready = 1'b1;
  logic mem_data = 1'b0;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;
  logic req_ready, out_valid, pixel_on, in_window;
  logic [14:0] read_address;
  int checks = 0;
  int passed = 0;
  int n_out = 0;
  bit exp_pix[$];
  bit exp_win[$];

  background_fetch #(.X0(X0), .Y0(Y0), .SCALE_SHIFT(2), .IMG_W_LOG2(7)) dut (
    .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
    .DrawX(DrawX), .DrawY(DrawY), .read_address(read_address), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready), .pixel_on(pixel_on), .in_window(in_window)
  );

  always #5 Clk = ~Clk;

  function automatic bit mem_bit(int a);
    return (a == 0) ? 1'b1 : 1'(((a * 37) >> 3) & 1);
  endfunction

  always @(posedge Clk) mem_data <= mem_bit(int'(read_address));

  function automatic bit ref_inside(int x, int y);
    int dx = (x - X0) & 2047;
    int dy = (y - Y0) & 2047;
    return (dx < 512) && (dy < 512);
  endfunction

  function automatic int ref_addr(int x, int y);
    int dx = (x - X0) & 2047;
    int dy = (y - Y0) & 2047;
    return ref_inside(x, y) ? (dy / 4) * 128 + dx / 4 : 0;
  endfunction

  task automatic check(string name, int act, int want);
    checks++;
    if (act == want) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, want);
  endtask

  always @(negedge Clk) begin
    if (Reset) begin
      exp_pix.delete();
      exp_win.delete();
    end else begin
      if (out_valid) begin
        if (exp_pix.size() == 0) check("unexpected_out", 1, 0);
        else begin
          check("model_pix", int'(pixel_on), int'(exp_pix[0]));
          check("model_win", int'(in_window), int'(exp_win[0]));
          if (out_ready) begin
            void'(exp_pix.pop_front());
            void'(exp_win.pop_front());
            n_out++;
          end
        end
      end
      if (req_valid && req_ready) begin
        exp_win.push_back(ref_inside(int'(DrawX), int'(DrawY)));
        exp_pix.push_back(ref_inside(int'(DrawX), int'(DrawY)) && mem_bit(ref_addr(int'(DrawX), int'(DrawY))));
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (req_ready) return;
    end
    check("ready_timeout", 0, 1);
  endtask

  task automatic send(int x, int y);
    req_valid = 1'b1;
    DrawX = 10'(x);
    DrawY = 10'(y);
    wait_ready();
    @(posedge Clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic lat_check(string name, int x, int y, int a, int p, int w);
    send(x, y);
    @(negedge Clk);
    check({name, "_addr"}, int'(read_address), a);
    check({name, "_early"}, int'(out_valid), 0);
    @(negedge Clk);
    check({name, "_valid"}, int'(out_valid), 1);
    check({name, "_pix"}, int'(pixel_on), p);
    check({name, "_win"}, int'(in_window), w);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0, w0, base;
    repeat (2) @(posedge Clk);
    #1;
    @(negedge Clk);
    check("rst_valid", int'(out_valid), 0);
    check("rst_pix", int'(pixel_on), 0);
    check("rst_win", int'(in_window), 0);
    check("rst_addr", int'(read_address), 0);
    check("rst_ready", int'(req_ready), 0);
    @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    check("rel_ready", int'(req_ready), 1);
    @(posedge Clk);
    #1;
    lat_check("origin", 64, 0, 0, 1, 1);
    lat_check("mid", 87, 8, 261, 1, 1);
    lat_check("zero_bit", 68, 0, 1, 0, 1);
    lat_check("corner", 575, 511, 16383, 1, 1);
    lat_check("left_out", 10, 0, 0, 0, 0);
    lat_check("right_out", 576, 0, 0, 0, 0);
    lat_check("below_out", 64, 512, 0, 0, 0);
    base = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          req_valid = 1'b1;
          DrawX = 10'(40 + i * 80);
          DrawY = 10'(i * 70);
          wait_ready();
          @(posedge Clk);
          #1;
        end
        req_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge Clk);
        #1 out_ready = 1'b0;
        @(negedge Clk);
        p0 = int'(pixel_on);
        w0 = int'(in_window);
        @(negedge Clk);
        check("stall_ready", int'(req_ready), 0);
        @(negedge Clk);
        check("stall_valid", int'(out_valid), 1);
        check("stall_pix", int'(pixel_on), p0);
        check("stall_win", int'(in_window), w0);
        @(posedge Clk);
        #1 out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 20 && exp_pix.size() != 0; i++) @(posedge Clk);
    #1;
    check("stream_count", n_out - base, 8);
    check("stream_drain", exp_pix.size(), 0);
    out_ready = 1'b0;
    req_valid = 1'b1;
    DrawX = 10'd100;
    DrawY = 10'd100;
    wait_ready();
    @(posedge Clk);
    #1 DrawX = 10'd120;
    wait_ready();
    @(posedge Clk);
    #1 req_valid = 1'b0;
    @(negedge Clk);
    check("full_valid", int'(out_valid), 1);
    check("full_ready", int'(req_ready), 0);
    @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk);
    #1 Reset = 1'b0;
    out_ready = 1'b1;
    @(negedge Clk);
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_pix", int'(pixel_on), 0);
    check("mid_rst_win", int'(in_window), 0);
    check("mid_rst_addr", int'(read_address), 0);
    check("mid_rst_ready", int'(req_ready), 1);
    @(posedge Clk);
    #1;
    lat_check("post_rst", 87, 8, 261, 1, 1);
    repeat (4) @(posedge Clk);
    #1;
    check("final_drain", exp_pix.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
